// File: rtl/spu_mem_stage.sv
// spu_mem_stage: MEM stage of the SPU pipeline.
// Performs quadword loads/stores to the local store over a req/ack handshake,
// stalls upstream while an access is outstanding, aborts an access that never
// gets an ack, and forwards results, RT and the branch decision to writeback.
module spu_mem_stage #(
  parameter int LS_ADDR_W = 14,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 reg_write_in,
  input  logic                 branch_in,
  input  logic                 zero_in,
  input  logic [31:0]          JumpPC_in,
  input  logic [127:0]         ALUResult_in,
  input  logic [127:0]         ReadData2_in,
  input  logic [6:0]           RegisterRT_in,
  output logic                 stall_out,
  output logic                 ls_req,
  output logic                 ls_we,
  output logic [LS_ADDR_W-1:0] ls_addr,
  output logic [127:0]         ls_wdata,
  input  logic                 ls_ack,
  input  logic [127:0]         ls_rdata,
  output logic                 valid_out,
  output logic                 reg_write_out,
  output logic [127:0]         result_out,
  output logic [6:0]           RegisterRT_out,
  output logic                 branch_taken_out,
  output logic [31:0]          branch_target_out,
  output logic                 err_out
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  state_t state_next;

  logic             issue_alu;
  logic             start_access;
  logic             ack_done;
  logic             timeout_done;
  logic [CNT_W-1:0] timeout_cnt;

  logic             lat_load;
  logic             lat_reg_write;
  logic [6:0]       lat_rt;
  logic [127:0]     lat_alu;
  logic             lat_taken;
  logic [31:0]      lat_target;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the one-cycle events that steer the datapath.
  // An ack in the last allowed cycle wins over the timeout.
  always_comb begin
    state_next   = state;
    issue_alu    = 1'b0;
    start_access = 1'b0;
    ack_done     = 1'b0;
    timeout_done = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (mem_read_in || mem_write_in) begin
            state_next   = ACCESS;
            start_access = 1'b1;
          end else begin
            issue_alu = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (ls_ack) begin
          state_next = IDLE;
          ack_done   = 1'b1;
        end else if (timeout_cnt == CNT_LAST) begin
          state_next   = IDLE;
          timeout_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall_out = (state == ACCESS);

  // Local-store request side: latch the instruction, hold the request stable
  // until it completes, and count unacknowledged ACCESS cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_req        <= 1'b0;
      ls_we         <= 1'b0;
      ls_addr       <= '0;
      ls_wdata      <= '0;
      timeout_cnt   <= '0;
      lat_load      <= 1'b0;
      lat_reg_write <= 1'b0;
      lat_rt        <= '0;
      lat_alu       <= '0;
      lat_taken     <= 1'b0;
      lat_target    <= '0;
    end else if (start_access) begin
      ls_req        <= 1'b1;
      ls_we         <= mem_write_in;
      ls_addr       <= ALUResult_in[100 +: LS_ADDR_W];
      ls_wdata      <= ReadData2_in;
      timeout_cnt   <= '0;
      lat_load      <= mem_read_in & ~mem_write_in;
      lat_reg_write <= reg_write_in;
      lat_rt        <= RegisterRT_in;
      lat_alu       <= ALUResult_in;
      lat_taken     <= branch_in & zero_in;
      lat_target    <= JumpPC_in;
    end else if (ack_done || timeout_done) begin
      ls_req      <= 1'b0;
      ls_we       <= 1'b0;
      timeout_cnt <= '0;
    end else if (state == ACCESS) begin
      timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

  // Writeback side: one valid pulse per instruction; outputs hold otherwise.
  // A timed-out access completes with a zero result and raises the sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out         <= 1'b0;
      reg_write_out     <= 1'b0;
      result_out        <= '0;
      RegisterRT_out    <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
      err_out           <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (issue_alu) begin
        valid_out         <= 1'b1;
        result_out        <= ALUResult_in;
        reg_write_out     <= reg_write_in;
        RegisterRT_out    <= RegisterRT_in;
        branch_taken_out  <= branch_in & zero_in;
        branch_target_out <= JumpPC_in;
      end else if (ack_done) begin
        valid_out         <= 1'b1;
        result_out        <= lat_load ? ls_rdata : lat_alu;
        reg_write_out     <= lat_load & lat_reg_write;
        RegisterRT_out    <= lat_rt;
        branch_taken_out  <= lat_taken;
        branch_target_out <= lat_target;
      end else if (timeout_done) begin
        valid_out        <= 1'b1;
        result_out       <= '0;
        reg_write_out    <= 1'b0;
        RegisterRT_out   <= lat_rt;
        branch_taken_out <= 1'b0;
        err_out          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spu_mem_stage.sv
// tb_spu_mem_stage: scoreboard bench for spu_mem_stage with a local-store
// responder and a behavioural reference model of the stage.
module tb_spu_mem_stage;

  localparam int LS_ADDR_W = 14;
  localparam int TIMEOUT   = 4;

  logic                 clk;
  logic                 reset;
  logic                 valid_in;
  logic                 mem_read_in;
  logic                 mem_write_in;
  logic                 reg_write_in;
  logic                 branch_in;
  logic                 zero_in;
  logic [31:0]          JumpPC_in;
  logic [127:0]         ALUResult_in;
  logic [127:0]         ReadData2_in;
  logic [6:0]           RegisterRT_in;
  logic                 stall_out;
  logic                 ls_req;
  logic                 ls_we;
  logic [LS_ADDR_W-1:0] ls_addr;
  logic [127:0]         ls_wdata;
  logic                 ls_ack;
  logic [127:0]         ls_rdata;
  logic                 valid_out;
  logic                 reg_write_out;
  logic [127:0]         result_out;
  logic [6:0]           RegisterRT_out;
  logic                 branch_taken_out;
  logic [31:0]          branch_target_out;
  logic                 err_out;

  typedef struct {
    logic [127:0] result;
    logic         regw;
    logic [6:0]   rt;
    logic         chk_rt;
    logic         btaken;
    logic [31:0]  target;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] ls_mem[int];
  logic [127:0] ref_mem[int];
  logic         err_model;
  int           n_checks;
  int           n_fail;

  spu_mem_stage #(.LS_ADDR_W(LS_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .branch_in(branch_in),
    .zero_in(zero_in), .JumpPC_in(JumpPC_in), .ALUResult_in(ALUResult_in),
    .ReadData2_in(ReadData2_in), .RegisterRT_in(RegisterRT_in), .stall_out(stall_out),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .valid_out(valid_out),
    .reg_write_out(reg_write_out), .result_out(result_out),
    .RegisterRT_out(RegisterRT_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of a never-written local-store line.
  function automatic logic [127:0] mem_default(input int idx);
    logic [31:0] i;
    i = idx;
    return {i ^ 32'hC0DE_0000, 32'h1234_5678 + i, ~i, 32'hFACE_0000 | i};
  endfunction

  function automatic logic [127:0] ls_read(input int idx);
    return ls_mem.exists(idx) ? ls_mem[idx] : mem_default(idx);
  endfunction

  function automatic logic [127:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : mem_default(idx);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issue one instruction, play the local store if it is a memory op, and
  // push the model's expected writeback. ack_at = ACCESS cycle of the ack,
  // 0 = never ack (timeout). Called and returns at posedge+1.
  task automatic applyStimulus(input logic rd, input logic wr, input logic rw,
                               input logic br, input logic z, input logic [31:0] jpc,
                               input logic [127:0] alu, input logic [127:0] wd,
                               input logic [6:0] rt, input int ack_at);
    exp_t        e;
    logic [31:0] byte_addr;
    int          idx;
    byte_addr = alu[127:96];
    idx = int'((byte_addr / 32'd16) % (32'd1 << LS_ADDR_W));
    e.rt = rt;
    e.chk_rt = 1'b1;
    e.target = jpc;
    e.btaken = br & z;
    if (!(rd || wr)) begin
      e.result = alu;
      e.regw = rw;
    end else if (ack_at == 0) begin
      e.result = '0;
      e.regw = 1'b0;
      e.chk_rt = 1'b0;
      e.btaken = 1'b0;
      err_model = 1'b1;
    end else if (wr) begin
      ref_mem[idx] = wd;
      e.result = alu;
      e.regw = 1'b0;
    end else begin
      e.result = ref_read(idx);
      e.regw = rw;
    end
    e.err = err_model;
    exp_q.push_back(e);

    valid_in = 1'b1;
    mem_read_in = rd;
    mem_write_in = wr;
    reg_write_in = rw;
    branch_in = br;
    zero_in = z;
    JumpPC_in = jpc;
    ALUResult_in = alu;
    ReadData2_in = wd;
    RegisterRT_in = rt;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    mem_read_in = 1'($urandom);
    mem_write_in = 1'($urandom);
    ALUResult_in = rand128();
    ReadData2_in = rand128();
    RegisterRT_in = 7'($urandom);
    if (!(rd || wr)) begin
      checkOutput("alu_latency_valid", valid_out, 1'b1);
      checkOutput("alu_no_stall", stall_out, 1'b0);
    end else begin
      checkOutput("issue_edge_no_valid", valid_out, 1'b0);
      for (int c = 1; c <= TIMEOUT; c++) begin
        checkOutput("access_stall", stall_out, 1'b1);
        checkOutput("access_req", ls_req, 1'b1);
        checkOutput("access_we", ls_we, wr);
        checkOutput("access_addr", ls_addr, idx);
        if (wr) checkOutput("access_wdata", ls_wdata, wd);
        if (c == ack_at) begin
          ls_ack = 1'b1;
          if (ls_we) ls_mem[int'(ls_addr)] = ls_wdata;
          ls_rdata = ls_read(int'(ls_addr));
        end else begin
          ls_rdata = rand128();
        end
        @(posedge clk);
        #1;
        ls_ack = 1'b0;
        if (c == ack_at) break;
      end
      checkOutput("complete_valid", valid_out, 1'b1);
      checkOutput("complete_stall_low", stall_out, 1'b0);
      checkOutput("complete_req_low", ls_req, 1'b0);
    end
  endtask

  // Pull reset mid-access and confirm the access is abandoned.
  task automatic resetMidAccess();
    mem_read_in = 1'b1;
    mem_write_in = 1'b0;
    reg_write_in = 1'b1;
    branch_in = 1'b0;
    ALUResult_in = {32'h0000_0200, 96'h0};
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    checkOutput("rst_pre_stall", stall_out, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_req_drop", ls_req, 1'b0);
    checkOutput("rst_stall_drop", stall_out, 1'b0);
    checkOutput("rst_err_clear", err_out, 1'b0);
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_result", result_out, 128'h0);
    checkOutput("rst_we", ls_we, 1'b0);
    exp_q.delete();
    err_model = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ls_ack = 1'b1;
      ls_rdata = rand128();
      @(posedge clk);
      #1;
      checkOutput("rst_late_ack_valid", valid_out, 1'b0);
      checkOutput("rst_late_ack_stall", stall_out, 1'b0);
    end
    ls_ack = 1'b0;
  endtask

  // Monitor: every valid_out pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (reset && valid_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", valid_out, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wb_result", result_out, mon_e.result);
        checkOutput("wb_reg_write", reg_write_out, mon_e.regw);
        checkOutput("wb_branch_taken", branch_taken_out, mon_e.btaken);
        checkOutput("wb_err", err_out, mon_e.err);
        if (mon_e.chk_rt) checkOutput("wb_rt", RegisterRT_out, mon_e.rt);
        if (mon_e.btaken) checkOutput("wb_branch_target", branch_target_out, mon_e.target);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          kind;
    int          ack_at;
    logic [31:0] baddr;
    n_checks = 0;
    n_fail = 0;
    err_model = 1'b0;
    reset = 1'b0;
    valid_in = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    reg_write_in = 1'b0;
    branch_in = 1'b0;
    zero_in = 1'b0;
    JumpPC_in = '0;
    ALUResult_in = '0;
    ReadData2_in = '0;
    RegisterRT_in = '0;
    ls_ack = 1'b0;
    ls_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", valid_out, 1'b0);
    checkOutput("reset_req", ls_req, 1'b0);
    checkOutput("reset_stall", stall_out, 1'b0);
    checkOutput("reset_err", err_out, 1'b0);
    checkOutput("reset_result", result_out, 128'h0);
    checkOutput("reset_reg_write", reg_write_out, 1'b0);
    checkOutput("reset_branch", branch_taken_out, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed: ALU pass-through");
    applyStimulus(0, 0, 1, 0, 0, 32'h0, {16{8'hA5}}, 128'h0, 7'd5, 0);

    $display("[TB] directed: load with ack in third ACCESS cycle");
    ls_mem[32'h13] = {8{16'hDEAD}};
    ref_mem[32'h13] = {8{16'hDEAD}};
    applyStimulus(1, 0, 1, 0, 0, 32'h0, {32'h0000_0130, 96'h0}, 128'h0, 7'd9, 3);

    $display("[TB] directed: store with wrapped address, ack in first cycle");
    applyStimulus(0, 1, 1, 0, 0, 32'h0, {32'h0004_0010, 96'h1234}, {4{32'hBEEF_0001}}, 7'd3, 1);
    applyStimulus(1, 0, 1, 0, 0, 32'h0, {32'h0000_0018, 96'h0}, 128'h0, 7'd4, 2);

    $display("[TB] directed: load and store together, ack in final cycle");
    applyStimulus(1, 1, 1, 0, 0, 32'h0, {32'h0000_0020, 96'h55}, {4{32'h0BAD_F00D}}, 7'd6, TIMEOUT);

    $display("[TB] directed: load timeout");
    applyStimulus(1, 0, 1, 0, 0, 32'h0, {32'h0000_0300, 96'h0}, 128'h0, 7'd7, 0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, {4{32'h0000_1111}}, 128'h0, 7'd8, 0);

    $display("[TB] directed: branches");
    applyStimulus(0, 0, 0, 1, 1, 32'h200, {4{32'h0}}, 128'h0, 7'd0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h200, {4{32'h1}}, 128'h0, 7'd0, 0);

    $display("[TB] directed: reset mid-access");
    resetMidAccess();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          valid_in = 1'b0;
          mem_read_in = 1'($urandom);
          mem_write_in = 1'($urandom);
          ls_ack = 1'($urandom);
          ls_rdata = rand128();
          @(posedge clk);
          #1;
        end
        ls_ack = 1'b0;
      end
      kind = $urandom_range(0, 4);
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      baddr = ($urandom_range(0, 3) << 18) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
      case (kind)
        0: applyStimulus(0, 0, 1'($urandom), 0, 0, $urandom, rand128(), rand128(), 7'($urandom), 0);
        1: applyStimulus(0, 0, 0, 1, 1'($urandom), $urandom, rand128(), rand128(), 7'($urandom), 0);
        2: applyStimulus(1, 0, 1'($urandom), 0, 0, $urandom, {baddr, 96'($urandom)}, rand128(), 7'($urandom), ack_at);
        3: applyStimulus(0, 1, 1'($urandom), 0, 0, $urandom, {baddr, 96'($urandom)}, rand128(), 7'($urandom), ack_at);
        default: applyStimulus(1, 1, 1'($urandom), 0, 0, $urandom, {baddr, 96'($urandom)}, rand128(), 7'($urandom), ack_at);
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
